// File: rtl/scan_sequencer_3bit_pkg.sv
// Shared constants and state type for the 3-bit channel scanner.
package scan_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_t;

endpackage

// File: rtl/scan_sequencer_3bit_next_ch.sv
// Rotated priority search: next set mask bit strictly above cur_idx, wrapping.
module scan_next_ch
  import scan_pkg::*;
(
  input  logic [SEL_W-1:0]  cur_idx,
  input  logic [NUM_CH-1:0] mask,
  output logic [SEL_W-1:0]  nxt_idx_c,
  output logic              wrap_c,
  output logic              none_c
);

  logic             found;
  logic [SEL_W-1:0] idx;

  // Walk cur+1 .. cur+8 (mod 8); offset 8 lands back on cur for single-channel masks.
  always_comb begin
    nxt_idx_c = cur_idx;
    found     = 1'b0;
    idx       = '0;
    for (int i = 1; i <= int'(NUM_CH); i++) begin
      idx = cur_idx + SEL_W'(i);
      if (!found && mask[idx]) begin
        nxt_idx_c = idx;
        found     = 1'b1;
      end
    end
    none_c = (mask == '0);
    wrap_c = !none_c && (nxt_idx_c <= cur_idx);
  end

endmodule

// File: rtl/scan_sequencer_3bit.sv
// Channel scanner driving a 3-to-8 decoder: dwell per channel, optional blank gap.
module scan_sequencer_3bit
  import scan_pkg::*;
#(
  parameter int unsigned DWELL = 4,
  parameter int unsigned BLANK = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [NUM_CH-1:0] mask,
  output logic [SEL_W-1:0]  sel,
  output logic              sel_en,
  output logic              busy,
  output logic              frame_done
);

  localparam bit               HAS_BLANK = (BLANK != 0);
  localparam logic [CNT_W-1:0] DWELL_LD  = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LD  = CNT_W'(HAS_BLANK ? BLANK - 1 : 0);

  scan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             sel_en_q, sel_en_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic             stop_pend_q, stop_pend_d;

  logic [SEL_W-1:0] cur_idx;
  logic [SEL_W-1:0] nxt_idx_c;
  logic             wrap_c;
  logic             none_c;
  logic             stop_eff;
  logic             advance;

  // From IDLE, searching above index 7 yields the lowest set bit.
  assign cur_idx  = (state_q == ST_IDLE) ? SEL_W'(NUM_CH - 1) : sel_q;
  assign stop_eff = stop_pend_q | stop;

  scan_next_ch u_next_ch (
    .cur_idx   (cur_idx),
    .mask      (mask),
    .nxt_idx_c (nxt_idx_c),
    .wrap_c    (wrap_c),
    .none_c    (none_c)
  );

  // Next-state, counter, pending-stop and output computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    frame_done_d = 1'b0;
    stop_pend_d  = stop_pend_q;
    advance      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop && !none_c) begin
          state_d = ST_DWELL;
          sel_d   = nxt_idx_c;
          cnt_d   = DWELL_LD;
        end
      end
      ST_DWELL: begin
        if (stop) stop_pend_d = 1'b1;
        if (cnt_q == '0) begin
          if (stop_eff) begin
            state_d = ST_IDLE;
          end else if (HAS_BLANK) begin
            state_d = ST_BLANK;
            cnt_d   = BLANK_LD;
          end else begin
            advance = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_BLANK: begin
        if (stop) stop_pend_d = 1'b1;
        if (cnt_q == '0) begin
          if (stop_eff) state_d = ST_IDLE;
          else          advance = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Mask is sampled here only; an empty mask ends the scan.
    if (advance) begin
      if (none_c) begin
        state_d = ST_IDLE;
      end else begin
        state_d      = ST_DWELL;
        sel_d        = nxt_idx_c;
        frame_done_d = wrap_c;
        cnt_d        = DWELL_LD;
      end
    end

    if (state_d == ST_IDLE) begin
      sel_d        = '0;
      cnt_d        = '0;
      stop_pend_d  = 1'b0;
      frame_done_d = 1'b0;
    end

    sel_en_d = (state_d == ST_DWELL);
    busy_d   = (state_d != ST_IDLE);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sel_q        <= '0;
      sel_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      stop_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      sel_en_q     <= sel_en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      stop_pend_q  <= stop_pend_d;
    end
  end

  assign sel        = sel_q;
  assign sel_en     = sel_en_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
